i2c_target_adxl357_emu: RTL



---
 rtl/i2c_target_adxl357_emu_if.sv | 14 +
 rtl/i2c_target_adxl357_emu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_adxl357_emu_if.sv
// I2C target pin bundle: raw SCL/SDA levels seen at the pads plus the open-drain SDA pull enable.
// Latency: none (wires only).
// Backpressure: none; the bus is open-drain and the target only ever pulls SDA low.
// Ports: i_scl / i_sda (pad levels into the target), o_sda_oe (1 = pull SDA low).
interface i2c_target_adxl357_emu_if;
  logic i_scl;
  logic i_sda;
  logic o_sda_oe;

  // master: the I2C controller side, which drives SCL/SDA and observes the target's pull-down
  modport master (output i_scl, output i_sda, input o_sda_oe);
  // slave: the emulated sensor
  modport slave (input i_scl, input i_sda, output o_sda_oe);
endinterface

// File: rtl/i2c_target_adxl357_emu.sv
// ADXL357 register-map emulator as an oversampled I2C target (7-bit address DEV_ADDR).
// Latency: pins -> decisions take 2 sync + FILT_LEN filter cycles; SDA drive changes the cycle after filtered SCL falls.
// Backpressure: none; never stretches SCL. Snapshot loads during a transaction are deferred to one cycle after STOP.
// Ports: i_clk/i_rst_n; bus (SCL/SDA/SDA-OE); i_accx/y/z, i_temp, i_load (snapshot in); o_drdy;
//        o_reg_wr/o_reg_wr_addr/o_reg_wr_data (host write strobe); o_busy (addressed START..STOP).
module i2c_target_adxl357_emu #(
  parameter logic [6:0] DEV_ADDR = 7'h1D,
  parameter int         FILT_LEN = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  i2c_target_adxl357_emu_if.slave     bus,
  input  logic [19:0]                 i_accx,
  input  logic [19:0]                 i_accy,
  input  logic [19:0]                 i_accz,
  input  logic [11:0]                 i_temp,
  input  logic                        i_load,
  output logic                        o_drdy,
  output logic                        o_reg_wr,
  output logic [7:0]                  o_reg_wr_addr,
  output logic [7:0]                  o_reg_wr_data,
  output logic                        o_busy
);
  localparam int CW = $clog2(FILT_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WR, ACK_WR, RD, RD_ACK
  } state_t;

  // ---------------- front end: sync + glitch filter, index 0 = SCL, 1 = SDA
  logic [1:0]    raw, s1, s2, flt;
  logic [CW-1:0] cnt [2];

  assign raw = {bus.i_sda, bus.i_scl};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1  <= 2'b11;
      s2  <= 2'b11;
      flt <= 2'b11;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        // a new level must persist FILT_LEN consecutive samples before it is accepted
        if (s2[i] != flt[i]) begin
          if (cnt[i] == CW'(FILT_LEN - 1)) begin
            flt[i] <= s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_d, sda_d, fall_d;
  logic scl_rise, scl_fall, start_c, stop_c;

  assign scl_f    = flt[0];
  assign sda_f    = flt[1];
  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_c  = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_c   = scl_f & scl_d & ~sda_d & sda_f;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
      fall_d <= 1'b0;
    end else begin
      scl_d  <= scl_f;
      sda_d  <= sda_f;
      fall_d <= scl_fall;  // all SDA drive updates happen on this delayed strobe
    end
  end

  // ---------------- register file and snapshot shadows
  state_t      state;
  logic [6:0]  sr;        // low 7 bits of the byte in flight; the 8th bit is taken live
  logic [2:0]  bit_cnt;
  logic [7:0]  ptr;
  logic        rw, phase, sda_oe, pend;
  logic [19:0] sh_x, sh_y, sh_z;
  logic [11:0] sh_t;
  logic [7:0]  reg_filter, reg_range, reg_power;
  logic [7:0]  rd_byte, rx_byte;

  assign rx_byte    = {sr, sda_f};
  assign bus.o_sda_oe = sda_oe;

  always_comb begin
    rd_byte = 8'h00;
    case (ptr)
      8'h00: rd_byte = 8'hAD;
      8'h01: rd_byte = 8'h1D;
      8'h02: rd_byte = 8'hED;
      8'h03: rd_byte = 8'h01;
      8'h06: rd_byte = {4'h0, sh_t[11:8]};
      8'h07: rd_byte = sh_t[7:0];
      8'h08: rd_byte = sh_x[19:12];
      8'h09: rd_byte = sh_x[11:4];
      8'h0A: rd_byte = {sh_x[3:0], 4'h0};
      8'h0B: rd_byte = sh_y[19:12];
      8'h0C: rd_byte = sh_y[11:4];
      8'h0D: rd_byte = {sh_y[3:0], 4'h0};
      8'h0E: rd_byte = sh_z[19:12];
      8'h0F: rd_byte = sh_z[11:4];
      8'h10: rd_byte = {sh_z[3:0], 4'h0};
      8'h28: rd_byte = reg_filter;
      8'h2C: rd_byte = reg_range;
      8'h2D: rd_byte = reg_power;
      default: rd_byte = 8'h00;
    endcase
  end

  // ---------------- protocol FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      sr            <= '0;
      bit_cnt       <= '0;
      ptr           <= 8'h00;
      rw            <= 1'b0;
      phase         <= 1'b0;
      sda_oe        <= 1'b0;
      pend          <= 1'b0;
      sh_x          <= '0;
      sh_y          <= '0;
      sh_z          <= '0;
      sh_t          <= '0;
      reg_filter    <= 8'h00;
      reg_range     <= 8'h81;
      reg_power     <= 8'h01;
      o_drdy        <= 1'b0;
      o_reg_wr      <= 1'b0;
      o_reg_wr_addr <= 8'h00;
      o_reg_wr_data <= 8'h00;
      o_busy        <= 1'b0;
    end else begin
      o_reg_wr <= 1'b0;
      if (stop_c) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        o_busy <= 1'b0;
        phase  <= 1'b0;
      end else if (start_c) begin
        // repeated START keeps the pointer so write-ptr/restart/read works
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        phase   <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            sr      <= {sr[5:0], sda_f};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (sr == DEV_ADDR) begin
                rw     <= sda_f;
                o_busy <= 1'b1;
                state  <= ACK_ADDR;
              end else begin
                state <= IDLE;
              end
            end
          end
          // phase 0: 8th fall -> assert ACK; phase 1: 9th fall -> release / hand over
          ACK_ADDR: if (fall_d) begin
            if (!phase) begin
              sda_oe <= 1'b1;
              phase  <= 1'b1;
            end else begin
              phase   <= 1'b0;
              bit_cnt <= '0;
              if (rw) begin
                sr     <= rd_byte[6:0];
                sda_oe <= ~rd_byte[7];
                state  <= RD;
              end else begin
                sda_oe <= 1'b0;
                state  <= PTR;
              end
            end
          end
          PTR: if (scl_rise) begin
            sr      <= {sr[5:0], sda_f};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr   <= rx_byte;
              state <= ACK_PTR;
            end
          end
          ACK_PTR, ACK_WR: if (fall_d) begin
            if (!phase) begin
              sda_oe <= 1'b1;
              phase  <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              phase   <= 1'b0;
              bit_cnt <= '0;
              state   <= WR;
            end
          end
          WR: if (scl_rise) begin
            sr      <= {sr[5:0], sda_f};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              o_reg_wr      <= 1'b1;
              o_reg_wr_addr <= ptr;
              o_reg_wr_data <= rx_byte;
              case (ptr)
                8'h28: reg_filter <= rx_byte;
                8'h2C: reg_range  <= rx_byte;
                8'h2D: reg_power  <= rx_byte;
                default: ;
              endcase
              ptr   <= ptr + 8'd1;
              state <= ACK_WR;
            end
          end
          RD: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= RD_ACK;
                if (ptr == 8'h08) o_drdy <= 1'b0;
              end
            end
            if (fall_d) begin
              sda_oe <= ~sr[6];
              sr     <= {sr[5:0], 1'b0};
            end
          end
          RD_ACK: begin
            if (fall_d && !phase) sda_oe <= 1'b0;
            if (scl_rise) begin
              if (sda_f) begin
                state <= IDLE;  // NACK: hold off until STOP or repeated START
              end else begin
                ptr   <= ptr + 8'd1;
                phase <= 1'b1;
              end
            end
            if (fall_d && phase) begin
              phase   <= 1'b0;
              sr      <= rd_byte[6:0];
              sda_oe  <= ~rd_byte[7];
              bit_cnt <= '0;
              state   <= RD;
            end
          end
          default: ;
        endcase
      end

      // snapshot: capture now when idle, otherwise once after the transaction closes
      if (i_load && o_busy) pend <= 1'b1;
      if ((i_load || pend) && !o_busy) begin
        sh_x   <= i_accx;
        sh_y   <= i_accy;
        sh_z   <= i_accz;
        sh_t   <= i_temp;
        pend   <= 1'b0;
        o_drdy <= 1'b1;
      end
    end
  end
endmodule
